// File: rtl/approx_umul_ha_pipe_if.sv
// Streaming operand/product bundle for approx_umul_ha_pipe.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : multiplier side (drives in_ready, product and its approx tag)
// Signals:
//   in_valid/in_ready          operand beat handshake
//   x, y                       unsigned operands, WIDTH bits
//   approx_en                  per-beat approximation request
//   out_valid/out_ready        product handshake
//   p                          2*WIDTH-bit product
//   p_approx                   approx_en that travelled with p
interface approx_umul_ha_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       x;
  logic [WIDTH-1:0]       y;
  logic                   approx_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     p;
  logic                   p_approx;

  modport master (
    output in_valid, x, y, approx_en, out_ready,
    input  in_ready, out_valid, p, p_approx
  );

  modport slave (
    input  in_valid, x, y, approx_en, out_ready,
    output in_ready, out_valid, p, p_approx
  );
endinterface

// File: rtl/approx_umul_ha_pipe.sv
// Pipelined unsigned WIDTHxWIDTH multiplier built from half-adder pair-row arrays.
// Rows x[2k] and x[2k+1] of the partial-product matrix share one HA array; array 0
// can drop its low columns (eliminated, then OR-only) when approx_en is set.
// Three register stages: arrays -> two reduced vectors -> final sum.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          slave side of the operand/product stream
//   cnt_clr      synchronous clear of approx_cnt (wins over an increment)
//   approx_cnt   saturating count of accepted beats with approx_en=1
module approx_umul_ha_pipe #(
  parameter int WIDTH     = 8,
  parameter int ELIM_COLS = 1,
  parameter int OR_COLS   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_umul_ha_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     approx_cnt
);
  localparam int PAIRS = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;

  // Handshake. Each stage loads when it is empty or the stage after it moves,
  // so bubbles are squeezed out even while the output is stalled.
  logic stall, accept, en1, en2, en3;
  logic s1_valid, s2_valid, out_valid_reg;

  assign stall        = out_valid_reg && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && bus.in_ready;
  assign en3          = !out_valid_reg || bus.out_ready;
  assign en2          = !s2_valid || en3;
  assign en1          = !s1_valid || en2;

  // Stage-1 combinational arrays. t_arr[k] bit c has weight 2^c,
  // b_arr[k] bit c (the carry of column c) has weight 2^(c+1).
  logic [WIDTH:0] t_arr [PAIRS];
  logic [WIDTH:0] b_arr [PAIRS];

  genvar gi, gc;
  generate
    for (gi = 0; gi < PAIRS; gi++) begin : g_pair
      logic [WIDTH:0] t_w;
      logic [WIDTH:0] b_w;
      for (gc = 0; gc <= WIDTH; gc++) begin : g_col
        if (gc == 0) begin : g_first
          assign t_w[gc] = bus.y[0] & bus.x[2*gi];
          assign b_w[gc] = 1'b0;
        end else if (gc == WIDTH) begin : g_last
          assign t_w[gc] = bus.y[WIDTH-1] & bus.x[2*gi+1];
          assign b_w[gc] = 1'b0;
        end else begin : g_mid
          logic a0, a1;
          assign a0 = bus.y[gc] & bus.x[2*gi];
          assign a1 = bus.y[gc-1] & bus.x[2*gi+1];
          if (gi == 0 && gc <= ELIM_COLS) begin : g_elim
            assign t_w[gc] = bus.approx_en ? 1'b0 : (a0 ^ a1);
            assign b_w[gc] = bus.approx_en ? 1'b0 : (a0 & a1);
          end else if (gi == 0 && gc <= ELIM_COLS + OR_COLS) begin : g_or
            // OR never exceeds the true column sum, so the result can only shrink.
            assign t_w[gc] = bus.approx_en ? (a0 | a1) : (a0 ^ a1);
            assign b_w[gc] = bus.approx_en ? 1'b0 : (a0 & a1);
          end else begin : g_exact
            assign t_w[gc] = a0 ^ a1;
            assign b_w[gc] = a0 & a1;
          end
        end
      end
      assign t_arr[gi] = t_w;
      assign b_arr[gi] = b_w;
    end
  endgenerate

  // Stage-1 registers.
  logic           s1_approx;
  logic [WIDTH:0] s1_t [PAIRS];
  logic [WIDTH:0] s1_b [PAIRS];

  // Stage-2 reduction: all sum words into one vector, all carry words into another.
  logic [PW-1:0] sum_t, sum_b;
  always_comb begin
    sum_t = '0;
    sum_b = '0;
    for (int k = 0; k < PAIRS; k++) begin
      sum_t = sum_t + (PW'(s1_t[k]) << (2 * k));
      sum_b = sum_b + (PW'(s1_b[k]) << (2 * k + 1));
    end
  end

  logic          s2_approx;
  logic [PW-1:0] s2_sum, s2_carry;
  logic [PW-1:0] p_reg;
  logic          p_approx_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_approx     <= 1'b0;
      for (int k = 0; k < PAIRS; k++) begin
        s1_t[k] <= '0;
        s1_b[k] <= '0;
      end
      s2_valid      <= 1'b0;
      s2_approx     <= 1'b0;
      s2_sum        <= '0;
      s2_carry      <= '0;
      out_valid_reg <= 1'b0;
      p_reg         <= '0;
      p_approx_reg  <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      if (en1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_approx <= bus.approx_en;
          for (int k = 0; k < PAIRS; k++) begin
            s1_t[k] <= t_arr[k];
            s1_b[k] <= b_arr[k];
          end
        end
      end
      if (en2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_approx <= s1_approx;
          s2_sum    <= sum_t;
          s2_carry  <= sum_b;
        end
      end
      // p only changes when a new product lands, so it is steady across stalls.
      if (en3) begin
        out_valid_reg <= s2_valid;
        if (s2_valid) begin
          p_reg        <= s2_sum + s2_carry;
          p_approx_reg <= s2_approx;
        end
      end
      if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (accept && bus.approx_en && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.p         = p_reg;
  assign bus.p_approx  = p_approx_reg;
  assign approx_cnt    = cnt_reg;
endmodule

// File: tb/tb_approx_umul_ha_pipe.sv
// Directed bench for approx_umul_ha_pipe: three instances share one stimulus
// stream (default, CNT_W=2, and no-approximation columns).
module tb_approx_umul_ha_pipe;
  localparam int TB_ELIM = 1;
  localparam int TB_OR   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic approx_en = 1'b0;
  logic out_ready = 1'b1;
  logic cnt_clr = 1'b0;
  logic [15:0] cnt_m;
  logic [1:0]  cnt_c;
  logic [15:0] cnt_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_umul_ha_pipe_if #(.WIDTH(8)) bus_m ();
  approx_umul_ha_pipe_if #(.WIDTH(8)) bus_c ();
  approx_umul_ha_pipe_if #(.WIDTH(8)) bus_e ();

  assign bus_m.in_valid = in_valid;  assign bus_c.in_valid = in_valid;  assign bus_e.in_valid = in_valid;
  assign bus_m.x = x;                assign bus_c.x = x;                assign bus_e.x = x;
  assign bus_m.y = y;                assign bus_c.y = y;                assign bus_e.y = y;
  assign bus_m.approx_en = approx_en; assign bus_c.approx_en = approx_en; assign bus_e.approx_en = approx_en;
  assign bus_m.out_ready = out_ready; assign bus_c.out_ready = out_ready; assign bus_e.out_ready = out_ready;

  approx_umul_ha_pipe #(.WIDTH(8)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m), .cnt_clr(cnt_clr), .approx_cnt(cnt_m));
  approx_umul_ha_pipe #(.WIDTH(8), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .cnt_clr(cnt_clr), .approx_cnt(cnt_c));
  approx_umul_ha_pipe #(.WIDTH(8), .ELIM_COLS(0), .OR_COLS(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(bus_e), .cnt_clr(cnt_clr), .approx_cnt(cnt_e));

  // Reference: exact product minus what the approximate columns of array 0 lose.
  // Eliminated column c loses (a0+a1)*2^c; an OR column loses (a0&a1)*2^c.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic en);
    int prod;
    int loss;
    int t0;
    int t1;
    prod = int'(a) * int'(b);
    loss = 0;
    if (en) begin
      for (int c = 1; c <= TB_ELIM + TB_OR; c++) begin
        t0 = int'(b[c] & a[0]);
        t1 = int'(b[c-1] & a[1]);
        if (c <= TB_ELIM) loss = loss + ((t0 + t1) << c);
        else              loss = loss + ((t0 & t1) << c);
      end
    end
    return 16'(prod - loss);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", bus_m.out_valid); end
    checks++; if (bus_m.p !== 16'd0) begin errors++; $display("FAIL reset_p got=%0d want=0", bus_m.p); end
    checks++; if (bus_m.p_approx !== 1'b0) begin errors++; $display("FAIL reset_p_approx got=%0b want=0", bus_m.p_approx); end
    checks++; if (cnt_m !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", cnt_m); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus_m.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", bus_m.in_ready); end
    $display("test_reset done");
  endtask

  // Accept edge is the first of three edges; out_valid rises after the third.
  task automatic test_exact();
    out_ready = 1'b1;
    in_valid = 1'b1; x = 8'd255; y = 8'd255; approx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL exact_lat1 got=%0b want=0", bus_m.out_valid); end
    @(negedge clk);
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL exact_lat2 got=%0b want=0", bus_m.out_valid); end
    @(negedge clk);
    checks++; if (bus_m.out_valid !== 1'b1) begin errors++; $display("FAIL exact_valid got=%0b want=1", bus_m.out_valid); end
    checks++; if (bus_m.p !== 16'd65025) begin errors++; $display("FAIL exact_p got=%0d want=65025", bus_m.p); end
    checks++; if (bus_m.p_approx !== 1'b0) begin errors++; $display("FAIL exact_p_approx got=%0b want=0", bus_m.p_approx); end
    @(negedge clk);
    $display("test_exact x=255 y=255 p=%0d", bus_m.p);
  endtask

  task automatic test_approx();
    logic [7:0]  vx [4];
    logic [7:0]  vy [4];
    logic [15:0] vp [4];
    logic [15:0] ve [4];
    vx = '{8'd3, 8'd255, 8'd2, 8'd1};
    vy = '{8'd3, 8'd255, 8'd1, 8'd1};
    vp = '{16'd5, 16'd65017, 16'd0, 16'd1};
    ve = '{16'd9, 16'd65025, 16'd2, 16'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = vx[i]; y = vy[i]; approx_en = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; approx_en = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus_m.out_valid !== 1'b1 || bus_m.p !== vp[i]) begin errors++;
        $display("FAIL approx_p[%0d] got=%0d valid=%0b want=%0d", i, bus_m.p, bus_m.out_valid, vp[i]); end
      checks++; if (bus_m.p_approx !== 1'b1) begin errors++; $display("FAIL approx_tag[%0d] got=%0b want=1", i, bus_m.p_approx); end
      checks++; if (bus_e.p !== ve[i]) begin errors++; $display("FAIL noapprox_p[%0d] got=%0d want=%0d", i, bus_e.p, ve[i]); end
      $display("test_approx x=%0d y=%0d p=%0d exact_inst=%0d", vx[i], vy[i], bus_m.p, bus_e.p);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  tx [8];
    logic [7:0]  ty [8];
    logic        ta [8];
    logic [15:0] tp [8];
    int sent, rcvd, cyc, extra;
    logic prev_stall;
    logic [15:0] prev_p;
    tx = '{8'd1, 8'd2, 8'd15, 8'd255, 8'd3, 8'd255, 8'd16, 8'd100};
    ty = '{8'd1, 8'd3, 8'd15, 8'd1,   8'd3, 8'd255, 8'd16, 8'd200};
    ta = '{1'b0, 1'b0, 1'b0, 1'b0,    1'b1, 1'b1,   1'b0,  1'b0};
    tp = '{16'd1, 16'd6, 16'd225, 16'd255, 16'd5, 16'd65017, 16'd256, 16'd20000};
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_p = '0;
    while (rcvd < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid  = (sent < 8);
      x = tx[sent % 8]; y = ty[sent % 8]; approx_en = ta[sent % 8];
      #1;
      if (prev_stall) begin
        checks++; if (bus_m.p !== prev_p) begin errors++; $display("FAIL b2b_stall_stable got=%0d want=%0d", bus_m.p, prev_p); end
      end
      if (bus_m.out_valid && out_ready) begin
        checks++; if (bus_m.p !== tp[rcvd] || bus_m.p_approx !== ta[rcvd]) begin errors++;
          $display("FAIL b2b_p[%0d] got=%0d/%0b want=%0d/%0b", rcvd, bus_m.p, bus_m.p_approx, tp[rcvd], ta[rcvd]); end
        $display("test_back_to_back out[%0d] p=%0d", rcvd, bus_m.p);
        rcvd++;
      end
      prev_stall = bus_m.out_valid && !out_ready;
      prev_p = bus_m.p;
      if (in_valid && bus_m.in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcvd !== 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", rcvd); end
    extra = 0;
    repeat (5) begin
      if (bus_m.out_valid) extra++;
      @(negedge clk);
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_duplicate got=%0d want=0", extra); end
  endtask

  task automatic test_reset_in_flight();
    int waited;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = 8'd5; y = 8'd5; approx_en = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; approx_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL rif_out_valid got=%0b want=0", bus_m.out_valid); end
    checks++; if (cnt_m !== 16'd0) begin errors++; $display("FAIL rif_cnt got=%0d want=0", cnt_m); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; x = 8'd7; y = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!bus_m.out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (bus_m.out_valid !== 1'b1 || bus_m.p !== 16'd63) begin errors++;
      $display("FAIL rif_first_p got=%0d valid=%0b want=63", bus_m.p, bus_m.out_valid); end
    $display("test_reset_in_flight first p=%0d", bus_m.p);
    @(negedge clk);
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++; if (cnt_m !== 16'd0) begin errors++; $display("FAIL cnt_clear got=%0d want=0", cnt_m); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; approx_en = 1'b1; x = 8'(i + 1); y = 8'd1;
      cnt_clr = (i == 4);
      @(negedge clk);
      if (i == 3) begin
        checks++; if (cnt_m !== 16'd4) begin errors++; $display("FAIL cnt_four got=%0d want=4", cnt_m); end
        checks++; if (cnt_c !== 2'd3) begin errors++; $display("FAIL cnt_sat_early got=%0d want=3", cnt_c); end
      end
    end
    in_valid = 1'b0; cnt_clr = 1'b0;
    checks++; if (cnt_m !== 16'd0) begin errors++; $display("FAIL cnt_clr_priority got=%0d want=0", cnt_m); end
    checks++; if (cnt_c !== 2'd0) begin errors++; $display("FAIL cnt_c_clr got=%0d want=0", cnt_c); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; approx_en = 1'b1; x = 8'd9; y = 8'd9;
      @(negedge clk);
    end
    in_valid = 1'b0; approx_en = 1'b0;
    checks++; if (cnt_m !== 16'd6) begin errors++; $display("FAIL cnt_six got=%0d want=6", cnt_m); end
    checks++; if (cnt_c !== 2'd3) begin errors++; $display("FAIL cnt_saturate got=%0d want=3", cnt_c); end
    checks++; if (cnt_e !== cnt_m) begin errors++; $display("FAIL cnt_inst_agree got=%0d want=%0d", cnt_e, cnt_m); end
    $display("test_counter cnt=%0d cnt_w2=%0d", cnt_m, cnt_c);
    repeat (4) @(negedge clk);
  endtask

  typedef struct packed {
    logic [15:0] pa;
    logic [15:0] pe;
    logic        ap;
  } exp_t;

  task automatic test_sweep();
    exp_t q[$];
    exp_t e;
    int sent, rcvd, cyc;
    localparam int N = 300;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < N && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < N);
      if (sent < 4) begin
        x = (sent[0]) ? 8'd255 : 8'd0; y = (sent[1]) ? 8'd255 : 8'd0; approx_en = 1'b1;
      end else begin
        x = 8'($urandom); y = 8'($urandom); approx_en = 1'($urandom);
      end
      #1;
      if (bus_m.out_valid && out_ready) begin
        e = q.pop_front();
        checks++; if (bus_m.p !== e.pa || bus_m.p_approx !== e.ap) begin errors++;
          $display("FAIL sweep_p[%0d] got=%0d/%0b want=%0d/%0b", rcvd, bus_m.p, bus_m.p_approx, e.pa, e.ap); end
        checks++; if (bus_e.p !== e.pe) begin errors++; $display("FAIL sweep_exact[%0d] got=%0d want=%0d", rcvd, bus_e.p, e.pe); end
        checks++; if (bus_m.p > e.pe) begin errors++; $display("FAIL sweep_bound[%0d] got=%0d want<=%0d", rcvd, bus_m.p, e.pe); end
        rcvd++;
      end
      if (in_valid && bus_m.in_ready) begin
        e.pa = model(x, y, approx_en);
        e.pe = 16'(int'(x) * int'(y));
        e.ap = approx_en;
        q.push_back(e);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcvd !== N) begin errors++; $display("FAIL sweep_count got=%0d want=%0d", rcvd, N); end
    $display("test_sweep beats=%0d", rcvd);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_exact();
    test_approx();
    test_back_to_back();
    test_reset_in_flight();
    test_counter();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
